// File: rtl/masked_pkg.sv
// Shared helpers for the masked HPC2 AND datapath:
// randomness sizing, pair indexing and share/lane bit placement.
package masked_pkg;

  function automatic int nrnd(input int d);
    return d * (d - 1) / 2;
  endfunction

  // Offset of pair (i<j) in a lane's randomness word
  function automatic int rnd_idx(input int d, input int i, input int j);
    return i * d - i * (i + 1) / 2 + (j - 1 - i);
  endfunction

  function automatic int shr_bit(input int w, input int s, input int k);
    return s * w + k;
  endfunction

endpackage

// File: rtl/hpc2_lane_core.sv
// One lane of the HPC2 masked AND: D shares, two register stages.
// Output shares are a pure XOR tree over stage-2 registers.
module hpc2_lane_core
  import masked_pkg::*;
#(
  parameter  int D = 2,
  localparam int R = nrnd(D)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en1,
  input  logic         en2,
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic [R-1:0] r,
  output logic [D-1:0] c
);

  (* keep = "true" *) logic [D-1:0] a1;
  (* keep = "true" *) logic [D-1:0] b1;
  (* keep = "true" *) logic [R-1:0] r1;
  (* keep = "true" *) logic [D-1:0] p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1 <= '0;
      b1 <= '0;
      r1 <= '0;
    end else if (en1) begin
      a1 <= a;
      b1 <= b;
      r1 <= r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2 <= '0;
    end else if (en2) begin
      p2 <= a1 & b1;
    end
  end

  for (genvar i = 0; i < D; i++) begin : g_i
    logic [D-1:0] t;
    for (genvar j = 0; j < D; j++) begin : g_j
      if (i == j) begin : g_p
        assign t[j] = p2[i];
      end else begin : g_x
        // r[i][j] and r[j][i] share one random bit
        localparam int K = (i < j) ? rnd_idx(D, i, j)
                                   : rnd_idx(D, j, i);
        (* keep = "true" *) logic v_q;
        (* keep = "true" *) logic u_q;
        (* keep = "true" *) logic w_q;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_q <= 1'b0;
            u_q <= 1'b0;
            w_q <= 1'b0;
          end else begin
            if (en1) v_q <= b[j] ^ r[K];
            if (en2) begin
              u_q <= ~a1[i] & r1[K];
              w_q <= a1[i] & v_q;
            end
          end
        end

        assign t[j] = u_q ^ w_q;
      end
    end
    assign c[i] = ^t;
  end

endmodule

// File: rtl/masked_and_hpc2_vec.sv
// Vectorised two-stage HPC2 masked AND with valid/ready flow control.
// Holds the handshake, inv_b injection and share/lane re-packing.
module masked_and_hpc2_vec
  import masked_pkg::*;
#(
  parameter  int D = 2,
  parameter  int W = 8,
  localparam int R = nrnd(D)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           inv_b,
  input  logic [D*W-1:0] ina,
  input  logic [D*W-1:0] inb,
  input  logic [W*R-1:0] rnd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D*W-1:0] out_c
);

  logic v1;
  logic v2;
  logic adv1;
  logic adv2;
  logic acc;
  logic en2;

  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;
  assign acc       = in_valid & adv1;
  // Stage 2 only loads real beats, so it never re-masks a held one
  assign en2       = v1 & adv2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
    end
  end

  for (genvar k = 0; k < W; k++) begin : g_lane
    logic [D-1:0] a_l;
    logic [D-1:0] b_l;
    logic [D-1:0] c_l;

    for (genvar s = 0; s < D; s++) begin : g_s
      localparam int B = shr_bit(W, s, k);
      assign a_l[s]   = ina[B];
      assign b_l[s]   = inb[B] ^ ((s == 0) ? inv_b : 1'b0);
      assign out_c[B] = c_l[s];
    end

    hpc2_lane_core #(
      .D(D)
    ) u_core (
      .clk  (clk),
      .rst_n(rst_n),
      .en1  (acc),
      .en2  (en2),
      .a    (a_l),
      .b    (b_l),
      .r    (rnd[k*R +: R]),
      .c    (c_l)
    );
  end

endmodule

// File: tb/tb_masked_and_hpc2_vec.sv
// Bench for masked_and_hpc2_vec: D=2/W=4 and D=3/W=8 instances,
// checked on recombined values against a&b' scoreboards.
module tb_masked_and_hpc2_vec;

  localparam int D  = 2;
  localparam int W  = 4;
  localparam int R  = 1;
  localparam int AW = D * W;
  localparam int RW = W * R;
  localparam int D3 = 3;
  localparam int W3 = 8;
  localparam int R3 = 3;
  localparam int AW3 = D3 * W3;
  localparam int RW3 = W3 * R3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          in_valid, in_ready, inv_b;
  logic          out_valid, out_ready;
  logic [AW-1:0] ina, inb, out_c;
  logic [RW-1:0] rnd;

  logic           in_valid3, in_ready3, inv_b3;
  logic           out_valid3, out_ready3;
  logic [AW3-1:0] ina3, inb3, out_c3;
  logic [RW3-1:0] rnd3;

  masked_and_hpc2_vec #(.D(D), .W(W)) u_d2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inv_b    (inv_b),
    .ina      (ina),
    .inb      (inb),
    .rnd      (rnd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_c    (out_c)
  );

  masked_and_hpc2_vec #(.D(D3), .W(W3)) u_d3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid3),
    .in_ready (in_ready3),
    .inv_b    (inv_b3),
    .ina      (ina3),
    .inb      (inb3),
    .rnd      (rnd3),
    .out_valid(out_valid3),
    .out_ready(out_ready3),
    .out_c    (out_c3)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]  q  [$];
  logic [W3-1:0] q3 [$];

  function automatic logic [W-1:0] rec(input logic [AW-1:0] x);
    return x[W-1:0] ^ x[2*W-1:W];
  endfunction

  function automatic logic [W3-1:0] rec3(input logic [AW3-1:0] x);
    return x[7:0] ^ x[15:8] ^ x[23:16];
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic no_pending(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got output, expected none pending", nm);
  endtask

  // Scoreboards: push a & b' on accept, pop on output handshake
  always @(negedge clk) begin
    #1;
    if (rst_n !== 1'b1) begin
      q.delete();
      q3.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) no_pending("d2_spurious");
        else chk("d2_stream", 32'(rec(out_c)), 32'(q.pop_front()));
      end
      if (in_valid && in_ready)
        q.push_back(rec(ina) & (rec(inb) ^ {W{inv_b}}));
      if (out_valid3 && out_ready3) begin
        if (q3.size() == 0) no_pending("d3_spurious");
        else chk("d3_stream", 32'(rec3(out_c3)), 32'(q3.pop_front()));
      end
      if (in_valid3 && in_ready3)
        q3.push_back(rec3(ina3) & (rec3(inb3) ^ {W3{inv_b3}}));
    end
  end

  typedef struct {
    logic [W-1:0] a0, a1, b0, b1, r;
    logic         inv;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [6];

  task automatic rand_d2();
    ina   = AW'($urandom);
    inb   = AW'($urandom);
    rnd   = RW'($urandom);
    inv_b = 1'($urandom);
  endtask

  logic [AW-1:0] hold;
  int            n_seen;
  logic [5:0]    x;

  initial begin
    tbl[0] = '{4'h3, 4'h9, 4'h5, 4'h9, 4'h6, 1'b0, 4'h8};
    tbl[1] = '{4'h3, 4'h9, 4'h5, 4'h9, 4'h6, 1'b1, 4'h2};
    tbl[2] = '{4'hF, 4'h0, 4'hF, 4'hF, 4'hA, 1'b0, 4'h0};
    tbl[3] = '{4'hF, 4'h0, 4'hF, 4'hF, 4'h5, 1'b1, 4'hF};
    tbl[4] = '{4'h5, 4'h5, 4'h7, 4'h2, 4'h3, 1'b0, 4'h0};
    tbl[5] = '{4'h6, 4'h0, 4'h3, 4'h0, 4'h9, 1'b1, 4'h4};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    ina = '0; inb = '0; rnd = '0; inv_b = 1'b0;
    in_valid3 = 1'b0; out_ready3 = 1'b1;
    ina3 = '0; inb3 = '0; rnd3 = '0; inv_b3 = 1'b0;

    // Reset state, with garbage on the inputs
    repeat (2) @(negedge clk);
    rand_d2();
    in_valid = 1'b1;
    #1;
    chk("rst_out_c", 32'(out_c), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Table vectors: latency 2 and exact recombination
    foreach (tbl[n]) begin
      @(negedge clk);
      in_valid = 1'b1;
      ina   = {tbl[n].a1, tbl[n].a0};
      inb   = {tbl[n].b1, tbl[n].b0};
      rnd   = tbl[n].r;
      inv_b = tbl[n].inv;
      @(negedge clk);
      in_valid = 1'b0;
      rand_d2();
      #1 chk("lat1_valid", 32'(out_valid), 0);
      @(negedge clk);
      #1 chk("lat2_valid", 32'(out_valid), 1);
      chk($sformatf("tbl%0d", n), 32'(rec(out_c)), 32'(tbl[n].exp));
    end

    // Back-to-back stream
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      rand_d2();
      #1 chk("stream_ready", 32'(in_ready), 1);
      if (n >= 2) chk("stream_ovalid", 32'(out_valid), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Backpressure: pipe fills to two beats
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 3) rand_d2();
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1 chk("bp_ready", 32'(in_ready), 32'(c < 2));
      if (c == 2) hold = out_c;
      if (c > 2) begin
        chk("bp_hold_c", 32'(out_c), 32'(hold));
        chk("bp_hold_v", 32'(out_valid), 1);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 1);
    n_seen = int'(out_valid);
    repeat (3) begin
      @(negedge clk);
      #1 n_seen += int'(out_valid);
    end
    chk("bp_count", 32'(n_seen), 2);

    // Reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_d2();
    @(negedge clk);
    rand_d2();
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("rst_pre_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_c", 32'(out_c), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1 chk("rst_no_stale", 32'(out_valid), 0);
    end

    // Random valid/ready traffic
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      rand_d2();
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1 chk("d2_drain", 32'(q.size()), 0);

    // D=3: exhaustive lane-0 share sweep
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      x = 6'(n);
      in_valid3 = 1'b1;
      ina3   = AW3'($urandom);
      inb3   = AW3'($urandom);
      rnd3   = RW3'($urandom);
      inv_b3 = 1'($urandom);
      ina3[0] = x[0]; ina3[8] = x[1]; ina3[16] = x[2];
      inb3[0] = x[3]; inb3[8] = x[4]; inb3[16] = x[5];
      #1 chk("d3_ready", 32'(in_ready3), 1);
    end
    @(negedge clk);
    in_valid3 = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("d3_drain", 32'(q3.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
